// File: rtl/seg_scan_mux_pkg.sv
// rtl/seg_scan_mux_pkg.sv - shared display scan constants and helpers
package seg_scan_mux_pkg;

    // Board-clock defaults: 50 MHz / 50000 = 1 kHz digit slot rate, 10 us dead time.
    localparam int REFRESH_DIV_DEF = 50000;
    localparam int DEAD_CYCLES_DEF = 500;

    // Common-anode boards drive the selected anode low.
    localparam bit AN_ACTIVE_LOW_DEF = 1'b1;

    // Digit index width; a single-digit display still keeps a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_mux_scan_prescaler.sv
// rtl/seg_scan_mux_scan_prescaler.sv - per-digit slot counter with dead-time flag
module scan_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic slot_start,
    output logic slot_end,
    output logic dead_active
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;

    // Slot counter: counts 0..REFRESH_DIV-1 and wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Slot flags decoded directly from the counter.
    always_comb begin
        slot_start  = (cnt == '0);
        slot_end    = (cnt == CNT_W'(REFRESH_DIV - 1));
        dead_active = (cnt < CNT_W'(DEAD_CYCLES));
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed 7-segment digit scanner with frame snapshot
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = REFRESH_DIV_DEF,
    parameter int DEAD_CYCLES   = DEAD_CYCLES_DEF,
    parameter bit AN_ACTIVE_LOW = AN_ACTIVE_LOW_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   en_i,
    output logic [3:0]            hex_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    generate
        if (N_DIGITS < 1 || DEAD_CYCLES < 1 || REFRESH_DIV <= DEAD_CYCLES) begin : g_bad_params
            $error("seg_scan_mux: illegal N_DIGITS/REFRESH_DIV/DEAD_CYCLES combination");
        end
    endgenerate

    logic                  slot_start;
    logic                  slot_end;
    logic                  dead_active;
    logic                  frame_start;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] snap_dig;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_en;
    logic [N_DIGITS-1:0]   an_act;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .slot_start  (slot_start),
        .slot_end    (slot_end),
        .dead_active (dead_active)
    );

    assign frame_start = slot_start && (idx == '0);

    // Digit index advance and once-per-frame input snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx      <= '0;
            snap_dig <= '0;
            snap_dp  <= '0;
            snap_en  <= '0;
        end else begin
            if (frame_start) begin
                snap_dig <= digits_i;
                snap_dp  <= dp_i;
                snap_en  <= en_i;
            end
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Output decode from registered state only; anode held off during dead time.
    always_comb begin
        hex_o  = 4'h0;
        dp_o   = 1'b0;
        an_act = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                hex_o     = snap_dig[4*k +: 4];
                dp_o      = snap_dp[k];
                an_act[k] = !dead_active && snap_en[k];
            end
        end
        an_o    = AN_ACTIVE_LOW ? ~an_act : an_act;
        frame_o = frame_start;
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - randomized scoreboard bench for seg_scan_mux
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  hex;
    logic        dpo;
    logic [3:0]  an;
    logic        frame;

    logic [3:0]  digits1;
    logic        dp1;
    logic        en1;
    logic [3:0]  hex1;
    logic        dpo1;
    logic        an1;
    logic        frame1;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          t;
    int          t1;
    logic [15:0] s_dig;
    logic [3:0]  s_dp;
    logic [3:0]  s_en;
    logic [3:0]  s1_dig;
    logic        s1_dp;
    logic        s1_en;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .N_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp), .en_i(en),
        .hex_o(hex), .dp_o(dpo), .an_o(an), .frame_o(frame)
    );

    seg_scan_mux #(
        .N_DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(1), .AN_ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .digits_i(digits1), .dp_i(dp1), .en_i(en1),
        .hex_o(hex1), .dp_o(dpo1), .an_o(an1), .frame_o(frame1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare both DUTs.
    task automatic step();
        int p, d, c, p1;
        logic [3:0] exp_an;
        @(posedge clk);
        if (rst) begin
            t = 0; s_dig = '0; s_dp = '0; s_en = '0;
            t1 = 0; s1_dig = '0; s1_dp = 1'b0; s1_en = 1'b0;
        end else begin
            if (t % 16 == 0) begin
                s_dig = digits; s_dp = dp; s_en = en;
            end
            t++;
            if (t1 % 4 == 0) begin
                s1_dig = digits1; s1_dp = dp1; s1_en = en1;
            end
            t1++;
        end
        #1;
        p = t % 16;
        d = p / 4;
        c = p % 4;
        exp_an = 4'hF;
        if (c >= 1 && s_en[d]) exp_an[d] = 1'b0;
        check("hex",   hex,   s_dig[4*d +: 4]);
        check("dp",    dpo,   s_dp[d]);
        check("an",    an,    exp_an);
        check("frame", frame, p == 0);
        check("one_anode", $countones(~an) <= 1, 1);
        p1 = t1 % 4;
        check("hex1",   hex1,   s1_dig);
        check("dp1",    dpo1,   s1_dp);
        check("an1",    an1,    (p1 >= 1) && s1_en);
        check("frame1", frame1, p1 == 0);
    endtask

    initial begin
        rst = 1'b1; digits = 16'h1234; dp = 4'h0; en = 4'hF;
        digits1 = 4'h7; dp1 = 1'b1; en1 = 1'b1;
        step();
        step();
        check("post_reset_an",    an,    4'hF);
        check("post_reset_frame", frame, 1);
        check("post_reset_hex",   hex,   4'h0);
        rst = 1'b0;

        // first frame with a mid-frame input change at cycle 6
        for (int i = 1; i < 16; i++) begin
            step();
            if (i == 1) begin
                check("first_lit_an",  an,  4'b1110);
                check("first_lit_hex", hex, 4'h4);
            end
            if (i == 4) begin
                check("dead_an",  an,  4'hF);
                check("dead_hex", hex, 4'h3);
            end
            if (i == 6) digits = 16'hABCD;
            if (i == 9) check("isolated_hex", hex, 4'h2);
        end
        step();
        step();
        check("new_frame_hex", hex, 4'hD);

        // blanking and decimal point
        en = 4'b0101; dp = 4'b0100;
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < 32; i++) begin
            step();
            check("blank_an_set", (an == 4'b1110) || (an == 4'b1011) || (an == 4'hF), 1);
            check("dp_digit2", dpo, (t % 16) / 4 == 2);
        end

        // all digits disabled: anodes dark, hex keeps scanning
        en = 4'h0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i >= 16) check("all_off_an", an, 4'hF);
        end
        en = 4'hF;

        // mid-scan reset while digit 2 is lit
        for (int i = 0; i < 20 && (t % 16) != 9; i++) step();
        check("at_cycle9", t % 16, 9);
        rst = 1'b1;
        step();
        check("mid_reset_an",    an,    4'hF);
        check("mid_reset_hex",   hex,   4'h0);
        check("mid_reset_frame", frame, 1);
        rst = 1'b0;
        step();
        check("restart_an", an, 4'b1110);

        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            digits  = 16'($urandom);
            dp      = 4'($urandom);
            en      = 4'($urandom);
            digits1 = 4'($urandom);
            dp1     = 1'($urandom);
            en1     = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
